// File: rtl/dave_bus_if.sv
// dave_bus_if: Z80-side bus and memory-side request signals for dave_bus.
//   CPU side : iorq, mreq, rfsh, m1, rd, wr (active-low strobes), a, d -> q, wait_n, irq
//   Interrupt: int_src (rising edge requests an interrupt)
//   Memory   : mem_a, mem_rd, mem_wr, mem_d -> mem_q, mem_ack
// master = CPU/memory environment, slave = dave_bus.
interface dave_bus_if;
  logic        iorq;
  logic        mreq;
  logic        rfsh;
  logic        m1;
  logic        rd;
  logic        wr;
  logic [15:0] a;
  logic [7:0]  d;
  logic [7:0]  q;
  logic        wait_n;
  logic        irq;
  logic        int_src;
  logic [21:0] mem_a;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q;
  logic        mem_ack;

  modport master (
    output iorq, mreq, rfsh, m1, rd, wr, a, d, int_src, mem_q, mem_ack,
    input  q, wait_n, irq, mem_a, mem_rd, mem_wr, mem_d
  );

  modport slave (
    input  iorq, mreq, rfsh, m1, rd, wr, a, d, int_src, mem_q, mem_ack,
    output q, wait_n, irq, mem_a, mem_rd, mem_wr, mem_d
  );
endinterface

// File: rtl/dave_bus.sv
// dave_bus: Z80 bus bridge with four 8-bit page registers mapping the 64 KiB CPU
// space onto a 22-bit physical memory, a wait-stated memory handshake, and a
// single edge-triggered interrupt source with enable/pending bits.
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   pe     : CPU positive-edge enable; bus sampling happens only when pe=1
//   bus    : dave_bus_if.slave (CPU strobes/address/data, interrupt, memory port)
module dave_bus #(
  parameter logic [7:0] PORT_BASE = 8'hB0,
  parameter logic [7:0] INT_PORT  = 8'hB4
) (
  input logic     clock,
  input logic     reset,
  input logic     pe,
  dave_bus_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] pg_q, pg_d;
  logic            en_q, en_d;
  logic            pend_q, pend_d;
  logic [2:0]      sync_q;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic [21:0]     mem_a_q, mem_a_d;
  logic [7:0]      mem_d_q, mem_d_d;
  logic [7:0]      q_q, q_d;

  logic [7:0] port, off, io_rdata;
  logic       page_hit, int_hit, edge_det, clr;

  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] remembers its previous
  // output so a 0->1 transition is seen exactly once per rising edge.
  assign edge_det = sync_q[1] & ~sync_q[2];

  assign port     = bus.a[7:0];
  assign off      = port - PORT_BASE;
  assign page_hit = (off[7:2] == 6'd0);
  assign int_hit  = (port == INT_PORT) && !page_hit;
  assign io_rdata = page_hit ? pg_q[off[1:0]] :
                    int_hit  ? {6'd0, pend_q, en_q} : 8'hFF;

  always_comb begin
    state_d  = state_q;
    pg_d     = pg_q;
    en_d     = en_q;
    clr      = 1'b0;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    mem_a_d  = mem_a_q;
    mem_d_d  = mem_d_q;
    q_d      = q_q;

    unique case (state_q)
      S_IDLE: begin
        if (pe && !bus.mreq && bus.rfsh && (!bus.rd || !bus.wr)) begin
          state_d  = S_MEM;
          mem_rd_d = !bus.rd;
          mem_wr_d = bus.rd && !bus.wr;
          mem_a_d  = {pg_q[bus.a[15:14]], bus.a[13:0]};
          mem_d_d  = bus.d;
        end else if (pe && !bus.iorq) begin
          if (!bus.m1) begin
            // Interrupt acknowledge: float-high vector, pending untouched.
            q_d = '1;
          end else begin
            if (!bus.rd) q_d = io_rdata;
            if (!bus.wr) begin
              if (page_hit) begin
                pg_d[off[1:0]] = bus.d;
              end else if (int_hit) begin
                en_d = bus.d[0];
                clr  = bus.d[1];
              end
            end
          end
        end
      end
      S_MEM: begin
        // mem_ack is a memory-side event, so it is taken regardless of pe.
        if (bus.mem_ack) begin
          state_d  = S_DONE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (mem_rd_q) q_d = bus.mem_q;
        end
      end
      S_DONE: begin
        if (pe && bus.mreq) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A newly detected edge overrides a simultaneous clear.
    pend_d = edge_det | (pend_q & ~clr);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pg_q     <= '0;
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
      sync_q   <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_a_q  <= '0;
      mem_d_q  <= '0;
      q_q      <= '1;
    end else begin
      state_q  <= state_d;
      pg_q     <= pg_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      sync_q   <= {sync_q[1:0], bus.int_src};
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      mem_a_q  <= mem_a_d;
      mem_d_q  <= mem_d_d;
      q_q      <= q_d;
    end
  end

  // wait_n derives from state so an asynchronous reset releases it at once.
  assign bus.wait_n = (state_q != S_MEM);
  assign bus.irq    = ~(pend_q & en_q);
  assign bus.q      = q_q;
  assign bus.mem_a  = mem_a_q;
  assign bus.mem_d  = mem_d_q;
  assign bus.mem_rd = mem_rd_q;
  assign bus.mem_wr = mem_wr_q;

endmodule

// File: tb/tb_dave_bus.sv
module tb_dave_bus;
  logic clock;
  logic reset;
  logic pe;

  dave_bus_if bus();

  dave_bus #(.PORT_BASE(8'hB0), .INT_PORT(8'hB4)) dut (
    .clock(clock),
    .reset(reset),
    .pe   (pe),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int K_MS = 0;  // memory request start
  localparam int K_MD = 1;  // memory request completion
  localparam int K_IO = 2;  // I/O read / interrupt acknowledge

  typedef struct {
    int          kind;
    logic [21:0] a;
    logic [7:0]  d;
    logic        is_rd;
    logic [7:0]  qv;
    int          waits;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic [7:0] pm [4];
  logic       en_m;
  logic       pend_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop(output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: -1, a: '0, d: '0, is_rd: 1'b0, qv: '0, waits: 0};
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: DUT produced a response with no expectation queued at %0t", $time);
    end else begin
      e  = sbq.pop_front();
      ok = 1'b1;
    end
  endtask

  function automatic logic [7:0] exp_io(input logic [7:0] p);
    if (p >= 8'hB0 && p <= 8'hB3) return pm[int'(p) - 'hB0];
    if (p == 8'hB4) return {6'd0, pend_m, en_m};
    return 8'hFF;
  endfunction

  task automatic bus_idle();
    bus.iorq = 1'b1; bus.mreq = 1'b1; bus.rfsh = 1'b1;
    bus.m1   = 1'b1; bus.rd   = 1'b1; bus.wr   = 1'b1;
  endtask

  task automatic io_wr(input logic [7:0] port, input logic [7:0] v);
    @(negedge clock);
    pe = 1'b1; bus.iorq = 1'b0; bus.m1 = 1'b1; bus.wr = 1'b0;
    bus.a = {8'($urandom), port}; bus.d = v;
    @(negedge clock);
    bus_idle();
    if (port >= 8'hB0 && port <= 8'hB3) pm[int'(port) - 'hB0] = v;
    else if (port == 8'hB4) begin
      en_m = v[0];
      if (v[1]) pend_m = 1'b0;
    end
  endtask

  task automatic io_rd(input logic [7:0] port);
    exp_t e;
    e = '{kind: K_IO, a: '0, d: '0, is_rd: 1'b1, qv: exp_io(port), waits: 0};
    sbq.push_back(e);
    @(negedge clock);
    pe = 1'b1; bus.iorq = 1'b0; bus.m1 = 1'b1; bus.rd = 1'b0;
    bus.a = {8'($urandom), port};
    @(negedge clock);
    bus_idle();
  endtask

  task automatic intack();
    exp_t e;
    e = '{kind: K_IO, a: '0, d: '0, is_rd: 1'b1, qv: 8'hFF, waits: 0};
    sbq.push_back(e);
    @(negedge clock);
    pe = 1'b1; bus.iorq = 1'b0; bus.m1 = 1'b0;
    @(negedge clock);
    bus_idle();
  endtask

  task automatic refresh();
    @(negedge clock);
    pe = 1'b1; bus.mreq = 1'b0; bus.rfsh = 1'b0;
    bus.rd = 1'($urandom); bus.a = 16'($urandom);
    @(negedge clock);
    bus_idle();
  endtask

  // k = clocks the request is outstanding before mem_ack is sampled (k >= 1)
  task automatic mem_op(input logic [15:0] addr, input logic is_rd, input logic [7:0] dv,
                        input int k, input logic [7:0] rdata);
    exp_t e;
    e = '{kind: K_MS, a: {pm[addr[15:14]], addr[13:0]}, d: dv, is_rd: is_rd, qv: '0, waits: 0};
    sbq.push_back(e);
    e = '{kind: K_MD, a: '0, d: '0, is_rd: is_rd, qv: rdata, waits: k};
    sbq.push_back(e);
    @(negedge clock);
    pe = 1'b1; bus.mreq = 1'b0; bus.rd = !is_rd; bus.wr = is_rd;
    bus.a = addr; bus.d = dv;
    @(negedge clock);
    for (int i = 1; i < k; i++) begin
      pe = 1'($urandom);
      bus.d = 8'($urandom);
      @(negedge clock);
    end
    pe = 1'($urandom);
    bus.mem_ack = 1'b1; bus.mem_q = rdata;
    @(negedge clock);
    bus.mem_ack = 1'b0; bus.mem_q = 8'($urandom);
    bus_idle();
    pe = 1'b1;
    @(negedge clock);
  endtask

  // Monitor / scoreboard checker
  initial begin : monitor
    exp_t        e;
    bit          ok;
    logic        prev_stb, in_mem, l_rd;
    logic [21:0] la;
    logic [7:0]  ld;
    int          wcnt;
    logic        c_pe, c_iorq, c_rd, c_m1, c_rst;
    prev_stb = 1'b0; in_mem = 1'b0; l_rd = 1'b0; la = '0; ld = '0; wcnt = 0;
    forever begin
      @(posedge clock);
      c_pe = pe; c_iorq = bus.iorq; c_rd = bus.rd; c_m1 = bus.m1; c_rst = reset;
      #1;
      if (!c_rst || !reset) begin
        prev_stb = 1'b0; in_mem = 1'b0; wcnt = 0;
      end else begin
        if ((bus.mem_rd || bus.mem_wr) && !prev_stb) begin
          pop(e, ok);
          if (ok) begin
            chk("mem_start_kind", 32'(e.kind), 32'(K_MS));
            chk("mem_a", 32'(bus.mem_a), 32'(e.a));
            chk("mem_d", 32'(bus.mem_d), 32'(e.d));
            chk("mem_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'({e.is_rd, ~e.is_rd}));
            la = e.a; ld = e.d; l_rd = e.is_rd;
          end
          in_mem = 1'b1; wcnt = 0;
        end
        if (in_mem) begin
          if (!bus.wait_n) begin
            wcnt++;
            chk("mem_hold", {bus.mem_a, bus.mem_d, bus.mem_rd, bus.mem_wr}, {la, ld, l_rd, ~l_rd});
          end else begin
            pop(e, ok);
            if (ok) begin
              chk("mem_done_kind", 32'(e.kind), 32'(K_MD));
              chk("wait_cycles", 32'(wcnt), 32'(e.waits));
              chk("mem_release", 32'({bus.mem_rd, bus.mem_wr}), 32'(0));
              if (e.is_rd) chk("mem_read_q", 32'(bus.q), 32'(e.qv));
            end
            in_mem = 1'b0;
          end
        end else begin
          chk("idle_bus", 32'({bus.wait_n, bus.mem_rd, bus.mem_wr}), 32'(3'b100));
        end
        if (c_pe && !c_iorq && (!c_rd || !c_m1)) begin
          pop(e, ok);
          if (ok) begin
            chk("io_kind", 32'(e.kind), 32'(K_IO));
            chk("io_q", 32'(bus.q), 32'(e.qv));
          end
        end
        prev_stb = bus.mem_rd | bus.mem_wr;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // Stimulus driver
  initial begin : driver
    int         lat;
    logic [7:0] p;
    bus_idle();
    bus.a = '0; bus.d = '0; bus.int_src = 1'b0; bus.mem_q = '0; bus.mem_ack = 1'b0;
    pe = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) pm[i] = '0;
    en_m = 1'b0; pend_m = 1'b0;

    #22;
    chk("reset_q", 32'(bus.q), 32'(8'hFF));
    chk("reset_wait_irq", 32'({bus.wait_n, bus.irq}), 32'(2'b11));
    chk("reset_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'(0));
    chk("reset_mem_a", 32'(bus.mem_a), 32'(0));
    chk("reset_mem_d", 32'(bus.mem_d), 32'(0));
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) io_rd(8'(8'hB0 + i));

    // Page 2 mapping for a read with three wait clocks
    io_wr(8'hB2, 8'h3F);
    mem_op(16'h8123, 1'b1, 8'h00, 3, 8'hC7);
    // Top page write
    io_wr(8'hB3, 8'hFF);
    mem_op(16'hC000, 1'b0, 8'h5A, 4, 8'h00);
    // Refresh cycles must not start a request
    refresh();
    refresh();
    // Undecoded port: write ignored, read returns FF
    io_wr(8'h7F, 8'h55);
    io_rd(8'h7F);
    for (int i = 0; i < 4; i++) io_rd(8'(8'hB0 + i));

    // Randomised traffic
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 6))
        0: io_wr(8'(8'hB0 + $urandom_range(0, 3)), 8'($urandom));
        1: begin
          p = 8'($urandom);
          io_wr(p, 8'($urandom));
        end
        2: io_rd(8'(8'hB0 + $urandom_range(0, 4)));
        3: io_rd(8'($urandom));
        4: mem_op(16'($urandom), 1'b1, 8'($urandom), $urandom_range(1, 4), 8'($urandom));
        5: mem_op(16'($urandom), 1'b0, 8'($urandom), $urandom_range(1, 4), 8'($urandom));
        default: begin
          if ($urandom_range(0, 1) == 1) refresh();
          else intack();
        end
      endcase
    end

    // Interrupt: enable, pulse, latency bound
    io_wr(8'hB4, 8'h01);
    @(negedge clock);
    bus.int_src = 1'b1;
    lat = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      if (lat == 0 && bus.irq == 1'b0) lat = i;
    end
    chk("irq_within_3", 32'(bus.irq), 32'(0));
    bus.int_src = 1'b0;
    pend_m = 1'b1;
    io_rd(8'hB4);
    intack();
    chk("irq_after_intack", 32'(bus.irq), 32'(0));
    io_wr(8'hB4, 8'h03);
    chk("irq_cleared", 32'(bus.irq), 32'(1));
    io_rd(8'hB4);

    // Edge detected in the same clock as a clear write: set wins
    if (lat == 0) lat = 3;
    @(negedge clock);
    bus.int_src = 1'b1;
    for (int i = 1; i < lat; i++) @(negedge clock);
    pe = 1'b1; bus.iorq = 1'b0; bus.m1 = 1'b1; bus.wr = 1'b0;
    bus.a = 16'h00B4; bus.d = 8'h03;
    @(negedge clock);
    bus_idle();
    bus.int_src = 1'b0;
    pend_m = 1'b1;
    chk("irq_set_wins", 32'(bus.irq), 32'(0));
    repeat (3) @(negedge clock);
    chk("irq_still_set", 32'(bus.irq), 32'(0));
    io_rd(8'hB4);
    io_wr(8'hB4, 8'h03);
    chk("irq_cleared2", 32'(bus.irq), 32'(1));

    // Reset during an outstanding memory read
    io_wr(8'hB1, 8'hA5);
    begin
      exp_t e;
      e = '{kind: K_MS, a: {pm[1], 14'h0042}, d: 8'h11, is_rd: 1'b1, qv: '0, waits: 0};
      sbq.push_back(e);
    end
    @(negedge clock);
    pe = 1'b1; bus.mreq = 1'b0; bus.rd = 1'b0; bus.a = 16'h4042; bus.d = 8'h11;
    @(negedge clock);
    @(negedge clock);
    chk("mem_pending_pre_reset", 32'({bus.mem_rd, bus.wait_n}), 32'(2'b10));
    reset = 1'b0;
    #1;
    chk("rst_async_release", 32'({bus.mem_rd, bus.mem_wr, bus.wait_n, bus.irq}), 32'(4'b0011));
    for (int i = 0; i < 4; i++) pm[i] = '0;
    en_m = 1'b0; pend_m = 1'b0;
    @(negedge clock);
    bus.mem_ack = 1'b1; bus.mem_q = 8'h99;
    @(negedge clock);
    bus.mem_ack = 1'b0;
    bus_idle();
    reset = 1'b1;
    @(negedge clock);
    bus.mem_ack = 1'b1; bus.mem_q = 8'hAA;
    @(negedge clock);
    bus.mem_ack = 1'b0;
    chk("late_ack_ignored", 32'({bus.mem_rd, bus.wait_n, bus.q}), 32'({1'b0, 1'b1, 8'hFF}));
    for (int i = 0; i < 5; i++) io_rd(8'(8'hB0 + i));

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sbq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dave_bus.md
DAVE_BUS -- requirements
Module: dave_bus

Interface
REQ-001 SHALL have parameter PORT_BASE, default 8'hB0: I/O address of page register 0; page registers 1-3 follow at PORT_BASE+1..+3.
REQ-002 SHALL have parameter INT_PORT, default 8'hB4: I/O address of the interrupt control/status register.
REQ-003 SHALL have port clock, input, 1: single system clock for all state.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port pe, input, 1: CPU positive-edge clock enable; all bus sampling and state changes occur only on clock edges where pe=1.
REQ-006 SHALL have inputs iorq, mreq, rfsh, m1, rd, wr, each 1 bit, active-low: Z80 bus strobes.
REQ-007 SHALL have input a, 16: CPU address.
REQ-008 SHALL have input d, 8: CPU write data.
REQ-009 SHALL have output q, 8: read data to the CPU.
REQ-010 SHALL have output wait_n, 1, active-low: CPU wait request.
REQ-011 SHALL have output irq, 1, active-low: CPU maskable interrupt.
REQ-012 SHALL have input int_src, 1: interrupt source; a rising edge requests an interrupt.
REQ-013 SHALL have output mem_a, 22: physical memory address.
REQ-014 SHALL have outputs mem_rd and mem_wr, each 1 bit, active-high: memory request strobes.
REQ-015 SHALL have output mem_d, 8: memory write data.
REQ-016 SHALL have input mem_q, 8: memory read data.
REQ-017 SHALL have input mem_ack, 1: memory completion, valid only while a request is pending.

Function
REQ-018 SHALL hold four 8-bit page registers P0-P3; mem_a = {P[a[15:14]], a[13:0]}.
REQ-019 SHALL implement the state machine IDLE -> MEM -> DONE -> IDLE.
REQ-020 In IDLE, on pe with mreq=0, rfsh=1 and (rd=0 or wr=0), SHALL enter MEM, assert mem_rd (if rd=0) or mem_wr (if wr=0), latch mem_a, latch d into mem_d, and drive wait_n=0 in the same clock.
REQ-021 SHALL ignore refresh cycles (mreq=0, rfsh=0): no strobe, wait_n stays 1.
REQ-022 In MEM, SHALL hold the strobe, mem_a, mem_d and wait_n=0 until mem_ack=1; mem_ack is sampled every clock, independent of pe.
REQ-023 On mem_ack in MEM, SHALL deassert the strobe, release wait_n=1, latch mem_q into q on reads, and enter DONE, all in the same clock.
REQ-024 In DONE, SHALL hold q and return to IDLE on the first pe with mreq=1.
REQ-025 SHALL service I/O cycles (iorq=0, m1=1) in IDLE with zero wait states; decode uses a[7:0] only.
REQ-026 SHALL, on an I/O write to PORT_BASE+n, load Pn from d on that pe; on an I/O read, drive q=Pn.
REQ-027 INT_PORT layout: bit0 = enable (R/W); bit1 = pending (read); writing bit1=1 clears pending; other bits read 0.
REQ-028 SHALL detect int_src rising edges through a two-flop synchroniser and set pending on each detected edge.
REQ-029 SHALL drive irq = ~(pending & enable).
REQ-030 If an edge is detected in the same clock as a clear write, SHALL leave pending at 1 (set wins).
REQ-031 SHALL drive q=8'hFF for I/O reads to undecoded ports and during interrupt acknowledge (iorq=0, m1=0); the acknowledge cycle SHALL NOT clear pending.
REQ-032 SHALL ignore iorq while in MEM or DONE.

Reset
REQ-033 While reset=0, SHALL force state IDLE, P0-P3=0, enable=0, pending=0, synchroniser=0, mem_rd=0, mem_wr=0, mem_a=0, mem_d=0, q=8'hFF, wait_n=1, irq=1.
REQ-034 Reset asserted during MEM SHALL drop mem_rd/mem_wr and release wait_n asynchronously; a mem_ack arriving after reset SHALL be ignored.

Verification
REQ-035 Write 8'h3F to port B2, then memory read at 16'h8123 with mem_ack three clocks later -> mem_a=22'h0FC123, wait_n=0 for exactly three clocks, q=mem_q.
REQ-036 Memory write at 16'hC000 with d=8'h5A, P3=8'hFF -> mem_wr=1, mem_a=22'h3FC000, mem_d=8'h5A, held until mem_ack.
REQ-037 Refresh cycle (mreq=0, rfsh=0) -> no mem_rd/mem_wr, wait_n=1.
REQ-038 Write 8'h01 to B4, then pulse int_src -> irq=0 within 3 clocks; read B4 returns 8'h03; write 8'h03 -> irq=1; edge coincident with the clear -> irq stays 0.
REQ-039 Assert reset in MEM, then send mem_ack -> mem_rd=0, wait_n=1 immediately, P0-P3 read back 8'h00, no state change on mem_ack.
REQ-040 I/O read of port 8'h7F -> q=8'hFF, no page register changed.
